// File: rtl/mul_pkg.sv
// Shared types for the sequential multiplier: op encodings, FSM states and
// the per-op operand signedness lookup.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mul_state_e;

  typedef struct packed {
    logic a_signed;
    logic b_signed;
  } mul_sgn_t;

  // MUL treats both operands as signed; the low half is identical either way.
  function automatic mul_sgn_t op_sign(mul_op_e op);
    mul_sgn_t s;
    s.a_signed = (op == MUL_OP_MUL) || (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
    s.b_signed = (op == MUL_OP_MUL) || (op == MUL_OP_MULH);
    return s;
  endfunction

endpackage

// File: rtl/mul_seq_if.sv
// Request/response bundle between the execute stage and mul_seq.
interface mul_seq_if
  import mul_pkg::*;
#(
  parameter int XLEN = 32
);
  logic              in_valid;
  logic              in_ready;
  mul_op_e           op;
  logic [XLEN-1:0]   ain;
  logic [XLEN-1:0]   bin;
  logic              kill;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   result;
  logic [2*XLEN-1:0] prod;

  modport master (
    output in_valid, op, ain, bin, kill, out_ready,
    input  in_ready, out_valid, result, prod
  );

  modport slave (
    input  in_valid, op, ain, bin, kill, out_ready,
    output in_ready, out_valid, result, prod
  );
endinterface

// File: rtl/mul_slice.sv
// Combinational (SLICE+1)x(SLICE+1) signed multiplier; each SLICE-bit input is
// sign- or zero-extended by its own flag.
module mul_slice #(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0]         a,
  input  logic                     a_sgn,
  input  logic [SLICE-1:0]         b,
  input  logic                     b_sgn,
  output logic signed [2*SLICE+1:0] p
);
  localparam int PW = 2*SLICE + 2;

  logic signed [SLICE:0] ax, bx;
  logic signed [PW-1:0]  ae, be;

  assign ax = {a_sgn & a[SLICE-1], a};
  assign bx = {b_sgn & b[SLICE-1], b};
  assign ae = PW'(ax);
  assign be = PW'(bx);
  assign p  = ae * be;
endmodule

// File: rtl/mul_seq.sv
// Multi-cycle RISC-V M-extension multiplier: one SLICE x SLICE partial product
// per cycle. Optional MUL_ZERO_SKIP_EN short-circuits zero operands.
module mul_seq
  import mul_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int SLICE = 16
) (
  input logic     clk,
  input logic     rst_n,
  mul_seq_if.slave bus
);
  localparam int NS = XLEN / SLICE;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;
  localparam int PW = 2*SLICE + 2;
  localparam int PL = 2*XLEN;

  mul_state_e        state_q, state_d;
  logic [XLEN-1:0]   a_q, b_q;
  mul_op_e           op_q;
  mul_sgn_t          sgn_q;
  logic [IW-1:0]     i_q, j_q;
  logic [PL-1:0]     acc_q;

  logic              accept, last;
  logic [SLICE-1:0]  a_sl, b_sl;
  logic              a_sl_sgn, b_sl_sgn;
  logic signed [PW-1:0] pp;
  logic [PL+PW-1:0]  pp_wide;
  logic [PL-1:0]     pp_ext, pp_sh;
  logic [31:0]       sh;

  assign accept = (state_q == ST_IDLE) && bus.in_valid && !bus.kill;

`ifdef MUL_ZERO_SKIP_EN
  logic skip_q;
  // A zero operand makes every partial product zero, so one RUN cycle suffices.
  assign last = skip_q || ((i_q == IW'(NS-1)) && (j_q == IW'(NS-1)));
`else
  assign last = (i_q == IW'(NS-1)) && (j_q == IW'(NS-1));
`endif

  // Slice i of ain times slice j of bin; only the top slice carries a sign.
  assign a_sl     = a_q[int'(i_q)*SLICE +: SLICE];
  assign b_sl     = b_q[int'(j_q)*SLICE +: SLICE];
  assign a_sl_sgn = sgn_q.a_signed && (i_q == IW'(NS-1));
  assign b_sl_sgn = sgn_q.b_signed && (j_q == IW'(NS-1));

  mul_slice #(.SLICE(SLICE)) u_slice (
    .a    (a_sl),
    .a_sgn(a_sl_sgn),
    .b    (b_sl),
    .b_sgn(b_sl_sgn),
    .p    (pp)
  );

  assign pp_wide = {{PL{pp[PW-1]}}, pp};
  assign pp_ext  = pp_wide[PL-1:0];
  assign sh      = 32'((int'(i_q) + int'(j_q)) * SLICE);
  assign pp_sh   = pp_ext << sh;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN:  if (last) state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.kill) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= MUL_OP_MUL;
      sgn_q <= '0;
      i_q   <= '0;
      j_q   <= '0;
      acc_q <= '0;
    end else if (bus.kill) begin
      i_q   <= '0;
      j_q   <= '0;
      acc_q <= '0;
    end else if (accept) begin
      a_q   <= bus.ain;
      b_q   <= bus.bin;
      op_q  <= bus.op;
      sgn_q <= op_sign(bus.op);
      i_q   <= '0;
      j_q   <= '0;
      acc_q <= '0;
    end else if (state_q == ST_RUN) begin
      acc_q <= acc_q + pp_sh;
      if (i_q == IW'(NS-1)) begin
        i_q <= '0;
        j_q <= j_q + 1'b1;
      end else begin
        i_q <= i_q + 1'b1;
      end
    end
  end

`ifdef MUL_ZERO_SKIP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         skip_q <= 1'b0;
    else if (bus.kill)  skip_q <= 1'b0;
    else if (accept)    skip_q <= (bus.ain == '0) || (bus.bin == '0);
  end
`endif

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.prod      = acc_q;
  assign bus.result    = (op_q == MUL_OP_MUL) ? acc_q[XLEN-1:0] : acc_q[PL-1:XLEN];
endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: 32/16 default instance plus a 64/16 instance.
module tb_mul_seq;
  import mul_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mul_seq_if #(.XLEN(32)) bus   ();
  mul_seq_if #(.XLEN(64)) bus64 ();

  mul_seq #(.XLEN(32), .SLICE(16)) u_dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  mul_seq #(.XLEN(64), .SLICE(16)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

  // Present a request at #1 after an edge; lat = edges after the accept edge
  // until out_valid is seen.
  task automatic run_op(input mul_op_e op, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    bus.op = op; bus.ain = a; bus.bin = b; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_op();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.prod !== 64'h0 || bus.result !== 32'h0) begin
      bad++;
      $display("FAIL reset_state rdy=%b vld=%b prod=%h res=%h exp rdy=1 vld=0 prod=0 res=0",
               bus.in_ready, bus.out_valid, bus.prod, bus.result);
    end
  endtask

  task automatic test_mulhu();
    int lat;
    run_op(MUL_OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    total++;
    if (lat !== 4) begin bad++; $display("FAIL mulhu_latency got=%0d exp=4", lat); end
    total++;
    if (bus.prod !== 64'hFFFF_FFFE_0000_0001) begin
      bad++; $display("FAIL mulhu_prod got=%h exp=fffffffe00000001", bus.prod);
    end
    total++;
    if (bus.result !== 32'hFFFF_FFFE) begin
      bad++; $display("FAIL mulhu_result got=%h exp=fffffffe", bus.result);
    end
    finish_op();
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL handshake_idle rdy=%b vld=%b exp rdy=1 vld=0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_mulh_mulhsu();
    int lat;
    run_op(MUL_OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    total++;
    if (bus.prod !== 64'h1 || bus.result !== 32'h0) begin
      bad++; $display("FAIL mulh_neg1 prod=%h res=%h exp prod=1 res=0", bus.prod, bus.result);
    end
    finish_op();
    run_op(MUL_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    total++;
    if (bus.prod !== 64'hFFFF_FFFF_0000_0001 || bus.result !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL mulhsu prod=%h res=%h exp prod=ffffffff00000001 res=ffffffff",
                      bus.prod, bus.result);
    end
    finish_op();
  endtask

  task automatic test_mul_hold();
    int lat;
    run_op(MUL_OP_MUL, 32'd7, 32'hFFFF_FFFD, lat);
    total++;
    if (bus.result !== 32'hFFFF_FFEB || bus.prod !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      bad++; $display("FAIL mul_result res=%h prod=%h exp res=ffffffeb prod=ffffffffffffffeb",
                      bus.result, bus.prod);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== 32'hFFFF_FFEB) begin
        bad++; $display("FAIL mul_hold cyc=%0d vld=%b rdy=%b res=%h exp vld=1 rdy=0 res=ffffffeb",
                        c, bus.out_valid, bus.in_ready, bus.result);
      end
    end
    finish_op();
  endtask

  task automatic test_kill();
    int lat;
    bit seen;
    bus.op = MUL_OP_MULHU; bus.ain = 32'hFFFF_FFFF; bus.bin = 32'hFFFF_FFFF; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.kill = 1'b1;
    @(posedge clk); #1;
    bus.kill = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.prod !== 64'h0) begin
      bad++; $display("FAIL kill_run rdy=%b vld=%b prod=%h exp rdy=1 vld=0 prod=0",
                      bus.in_ready, bus.out_valid, bus.prod);
    end
    seen = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (bus.out_valid === 1'b1) seen = 1'b1; end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL kill_no_valid got=%b exp=0", seen); end
    run_op(MUL_OP_MULHU, 32'h0001_0000, 32'h0001_0000, lat);
    total++;
    if (lat !== 4 || bus.prod !== 64'h0000_0001_0000_0000 || bus.result !== 32'h1) begin
      bad++; $display("FAIL after_kill lat=%0d prod=%h res=%h exp lat=4 prod=0000000100000000 res=1",
                      lat, bus.prod, bus.result);
    end
    finish_op();
  endtask

  task automatic test_kill_accept();
    bit seen;
    bus.op = MUL_OP_MUL; bus.ain = 32'd3; bus.bin = 32'd5;
    bus.in_valid = 1'b1; bus.kill = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.kill = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL kill_accept rdy=%b exp=1", bus.in_ready); end
    seen = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (bus.out_valid === 1'b1) seen = 1'b1; end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL kill_accept_valid got=%b exp=0", seen); end
  endtask

  task automatic test_async_reset();
    bus.op = MUL_OP_MULHU; bus.ain = 32'hFFFF_FFFF; bus.bin = 32'hFFFF_FFFF; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    total++;
    if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL pre_reset_busy rdy=%b exp=0", bus.in_ready); end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.prod !== 64'h0 || bus.result !== 32'h0) begin
      bad++; $display("FAIL async_reset rdy=%b vld=%b prod=%h res=%h exp rdy=1 vld=0 prod=0 res=0",
                      bus.in_ready, bus.out_valid, bus.prod, bus.result);
    end
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_xlen64();
    int lat;
    bus64.op = MUL_OP_MULHU; bus64.ain = 64'hFFFF_FFFF_FFFF_FFFF; bus64.bin = 64'd2;
    bus64.in_valid = 1'b1;
    @(posedge clk); #1;
    bus64.in_valid = 1'b0;
    lat = 0;
    while (bus64.out_valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
    total++;
    if (lat !== 16 || bus64.result !== 64'h1 || bus64.prod !== 128'h1_FFFF_FFFF_FFFF_FFFE) begin
      bad++; $display("FAIL xlen64 lat=%0d res=%h prod=%h exp lat=16 res=1 prod=1fffffffffffffffe",
                      lat, bus64.result, bus64.prod);
    end
    bus64.out_ready = 1'b1;
    @(posedge clk); #1;
    bus64.out_ready = 1'b0;
  endtask

  task automatic test_zero();
    int lat;
    int exp_lat;
`ifdef MUL_ZERO_SKIP_EN
    exp_lat = 1;
`else
    exp_lat = 4;
`endif
    run_op(MUL_OP_MULH, 32'h0, 32'h1234_5678, lat);
    total++;
    if (lat !== exp_lat || bus.prod !== 64'h0 || bus.result !== 32'h0) begin
      bad++; $display("FAIL zero_operand lat=%0d prod=%h res=%h exp lat=%0d prod=0 res=0",
                      lat, bus.prod, bus.result, exp_lat);
    end
    finish_op();
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.op = MUL_OP_MUL; bus.ain = '0; bus.bin = '0;
    bus.kill = 1'b0; bus.out_ready = 1'b0;
    bus64.in_valid = 1'b0; bus64.op = MUL_OP_MUL; bus64.ain = '0; bus64.bin = '0;
    bus64.kill = 1'b0; bus64.out_ready = 1'b0;
    #1;
    test_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_mulhu();
    test_mulh_mulhsu();
    test_mul_hold();
    test_kill();
    test_kill_accept();
    test_async_reset();
    test_reset();
    test_xlen64();
    test_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
